io_input_port: RTL and testbench

//  Input-side responder of the memory-mapped IO decoder: the button/switch -> CPU path.
//  The seven-segment display driver is the CPU -> board path.

---
 rtl/io_pkg.sv | 11 +
 rtl/io_debouncer.sv | 55 +++++
 rtl/io_input_port.sv | 99 +++++++++
 tb/tb_io_input_port.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared constants for the button/switch input port: register offsets and STATUS bit positions.
package io_pkg;

   localparam logic [7:0] IO_STATUS = 8'h80;
   localparam logic [7:0] IO_SWDATA = 8'h84;
   localparam logic [7:0] IO_LIVE   = 8'h8C;

   localparam int unsigned RDY_L = 0;
   localparam int unsigned RDY_R = 1;

endpackage

// File: rtl/io_debouncer.sv
// Button synchroniser and debouncer; emits the debounced level and a one-cycle press pulse
// in the same cycle the level is about to rise.
module io_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned CNT_W           = 20,
   parameter int unsigned SYNC_STAGES     = 2
) (
   input  logic clk_i,
   input  logic reset_ni,
   input  logic btn_i,
   output logic deb_o,
   output logic press_o
);

   localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   deb_q, deb_d;
   logic                   sync_lvl;

   assign sync_d   = {sync_q[SYNC_STAGES-2:0], btn_i};
   assign sync_lvl = sync_q[SYNC_STAGES-1];

   always_comb begin
      cnt_d   = cnt_q;
      deb_d   = deb_q;
      press_o = 1'b0;
      if (sync_lvl == deb_q) begin
         cnt_d = '0;
      end else if (cnt_q == CntMax) begin
         deb_d   = sync_lvl;
         cnt_d   = '0;
         // Only a rising debounced level counts as a press.
         press_o = sync_lvl;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         sync_q <= '0;
         cnt_q  <= '0;
         deb_q  <= 1'b0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         deb_q  <= deb_d;
      end
   end

   assign deb_o = deb_q;

endmodule

// File: rtl/io_input_port.sv
// Memory-mapped input port: debounced BTNL/BTNR presses capture SW and set sticky ready flags
// which the core polls and clears through the STATUS register.
module io_input_port
   import io_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned CNT_W           = 20,
   parameter int unsigned SYNC_STAGES     = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        btn_l,
   input  logic        btn_r,
   input  logic [15:0] sw,
   input  logic [7:0]  addr,
   input  logic        io_sel,
   input  logic        we,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq_pend
);

   logic        deb_l, deb_r, press_l, press_r;
   logic [15:0] sw_s1_q, sw_s2_q;
   logic [15:0] sw_cap_q, sw_cap_d;
   logic        rdy_l_q, rdy_l_d, rdy_r_q, rdy_r_d;
   logic        clr_wr;
   logic        unused_sig;

   io_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .SYNC_STAGES     (SYNC_STAGES)
   ) u_deb_l (
      .clk_i    (clk),
      .reset_ni (reset_n),
      .btn_i    (btn_l),
      .deb_o    (deb_l),
      .press_o  (press_l)
   );

   io_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .SYNC_STAGES     (SYNC_STAGES)
   ) u_deb_r (
      .clk_i    (clk),
      .reset_ni (reset_n),
      .btn_i    (btn_r),
      .deb_o    (deb_r),
      .press_o  (press_r)
   );

   assign unused_sig = ^{deb_l, deb_r, wdata[31:2]};
   assign clr_wr     = io_sel && we && (addr == IO_STATUS);

   // Press is applied after the clear so that a coincident press keeps the flag set.
   always_comb begin
      rdy_l_d  = rdy_l_q;
      rdy_r_d  = rdy_r_q;
      sw_cap_d = sw_cap_q;
      if (clr_wr && wdata[RDY_L]) rdy_l_d = 1'b0;
      if (clr_wr && wdata[RDY_R]) rdy_r_d = 1'b0;
      if (press_l) rdy_l_d = 1'b1;
      if (press_r) rdy_r_d = 1'b1;
      if (press_l || press_r) sw_cap_d = sw_s2_q;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sw_s1_q  <= '0;
         sw_s2_q  <= '0;
         sw_cap_q <= '0;
         rdy_l_q  <= 1'b0;
         rdy_r_q  <= 1'b0;
      end else begin
         sw_s1_q  <= sw;
         sw_s2_q  <= sw_s1_q;
         sw_cap_q <= sw_cap_d;
         rdy_l_q  <= rdy_l_d;
         rdy_r_q  <= rdy_r_d;
      end
   end

   always_comb begin
      rdata = 32'h0;
      if (io_sel) begin
         case (addr)
            IO_STATUS: rdata = {30'b0, rdy_r_q, rdy_l_q};
            IO_SWDATA: rdata = {16'b0, sw_cap_q};
            IO_LIVE:   rdata = {16'b0, sw_s2_q};
            default:   rdata = 32'h0;
         endcase
      end
   end

   assign irq_pend = rdy_l_q | rdy_r_q;

endmodule

// File: tb/tb_io_input_port.sv
// Scoreboard bench for io_input_port: stimulus queues expected reads, a negedge monitor checks them.
module tb_io_input_port;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        btn_l = 1'b0, btn_r = 1'b0;
   logic [15:0] sw = '0;
   logic [7:0]  addr = '0;
   logic        io_sel = 1'b0, we = 1'b0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        irq_pend;

   typedef struct {
      string       name;
      bit          is_irq;
      logic [31:0] exp;
   } exp_t;

   exp_t exp_q[$];
   logic chk_req = 1'b0;
   int   n_checks = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   io_input_port #(
      .DEBOUNCE_CYCLES (4),
      .CNT_W           (3),
      .SYNC_STAGES     (2)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .btn_l    (btn_l),
      .btn_r    (btn_r),
      .sw       (sw),
      .addr     (addr),
      .io_sel   (io_sel),
      .we       (we),
      .wdata    (wdata),
      .rdata    (rdata),
      .irq_pend (irq_pend)
   );

   // Monitor: pops one expectation per presented read and compares.
   always @(negedge clk) begin
      if (chk_req) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL scoreboard: read presented with no expectation queued");
         end else begin
            exp_t e;
            logic [31:0] act;
            e   = exp_q.pop_front();
            act = e.is_irq ? {31'b0, irq_pend} : rdata;
            if (act === e.exp) n_pass++;
            else $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic rd(input string name, input logic [7:0] a, input logic sel,
                     input logic [31:0] exp);
      exp_t e;
      e.name = name; e.is_irq = 1'b0; e.exp = exp;
      exp_q.push_back(e);
      io_sel = sel; addr = a; chk_req = 1'b1;
      step();
      io_sel = 1'b0; chk_req = 1'b0;
   endtask

   task automatic chk_irq(input string name, input logic exp);
      exp_t e;
      e.name = name; e.is_irq = 1'b1; e.exp = {31'b0, exp};
      exp_q.push_back(e);
      chk_req = 1'b1;
      step();
      chk_req = 1'b0;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      io_sel = 1'b1; we = 1'b1; addr = a; wdata = d;
      step();
      io_sel = 1'b0; we = 1'b0; wdata = '0;
   endtask

   task automatic press(input bit right);
      if (right) btn_r = 1'b1; else btn_l = 1'b1;
      steps(8);
      if (right) btn_r = 1'b0; else btn_l = 1'b0;
      steps(8);
   endtask

   initial begin
      // 1. reset
      step();
      rd("rst_status", 8'h80, 1'b1, 32'h0);
      rd("rst_swdata", 8'h84, 1'b1, 32'h0);
      chk_irq("rst_irq", 1'b0);
      reset_n = 1'b1;
      rd("post_rst_status", 8'h80, 1'b1, 32'h0);
      rd("post_rst_swdata", 8'h84, 1'b1, 32'h0);

      // 2. left press latency and capture
      sw = 16'hA5A5;
      steps(4);
      btn_l = 1'b1;
      steps(5);
      rd("lat_before", 8'h80, 1'b1, 32'h0);
      rd("lat_at6", 8'h80, 1'b1, 32'h1);
      rd("cap_a5a5", 8'h84, 1'b1, 32'h0000A5A5);
      btn_l = 1'b0;
      steps(10);
      rd("after_release", 8'h80, 1'b1, 32'h1);

      // 3. bounce on right produces nothing
      btn_r = 1'b1; step(); btn_r = 1'b0; step();
      btn_r = 1'b1; step(); btn_r = 1'b0;
      steps(8);
      rd("bounce_status", 8'h80, 1'b1, 32'h1);
      chk_irq("bounce_irq", 1'b1);

      // 4. clear flags one at a time
      press(1'b1);
      rd("both_set", 8'h80, 1'b1, 32'h3);
      wr(8'h80, 32'h1);
      rd("clr_l", 8'h80, 1'b1, 32'h2);
      wr(8'h84, 32'h2);
      rd("clr_wrong_addr", 8'h80, 1'b1, 32'h2);
      wr(8'h80, 32'h2);
      rd("clr_r", 8'h80, 1'b1, 32'h0);
      chk_irq("clr_irq", 1'b0);

      // 5. press coincident with clear: press wins
      btn_l = 1'b1;
      steps(5);
      wr(8'h80, 32'h1);
      rd("press_vs_clear", 8'h80, 1'b1, 32'h1);
      btn_l = 1'b0;
      steps(10);

      // 6. latest capture wins, LIVE latency, decode misses
      sw = 16'h1234;
      press(1'b0);
      rd("cap_1234", 8'h84, 1'b1, 32'h00001234);
      sw = 16'hBEEF;
      press(1'b1);
      rd("cap_beef", 8'h84, 1'b1, 32'h0000BEEF);
      rd("both_status", 8'h80, 1'b1, 32'h3);
      sw = 16'h5A5A;
      rd("live_c0", 8'h8C, 1'b1, 32'h0000BEEF);
      rd("live_c1", 8'h8C, 1'b1, 32'h0000BEEF);
      rd("live_c2", 8'h8C, 1'b1, 32'h00005A5A);
      rd("swdata_uncaptured", 8'h84, 1'b1, 32'h0000BEEF);
      rd("unmapped_addr", 8'h88, 1'b1, 32'h0);
      rd("no_sel", 8'h80, 1'b0, 32'h0);

      // Reset mid-debounce discards the partial count
      wr(8'h80, 32'h3);
      btn_r = 1'b1;
      steps(3);
      reset_n = 1'b0;
      btn_r = 1'b0;
      step();
      reset_n = 1'b1;
      steps(10);
      rd("mid_deb_reset", 8'h80, 1'b1, 32'h0);
      rd("mid_deb_swdata", 8'h84, 1'b1, 32'h0);

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
